// File: rtl/alt_vipcti131_common_pkg.sv
// ----------------------------------------------------------------------------
// alt_vipcti131_common_pkg
//
// Purpose : Shared definitions for the VIP CTI raster sequencer slice.
//           Holds the sequencer state encoding and the default widths used
//           by the sequencer top and its axis counter.
//
// Contents: DEF_H_WIDTH, DEF_V_WIDTH, DEF_TICKS_WIDTH  - width defaults
//           seqState_t                                - sequencer FSM states
//           isCounting()                              - true in states that
//                                                       track raster position
// ----------------------------------------------------------------------------
package alt_vipcti131_common_pkg;

    localparam int DEF_H_WIDTH     = 12;
    localparam int DEF_V_WIDTH     = 12;
    localparam int DEF_TICKS_WIDTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_RELOCK   = 2'd3
    } seqState_t;

    // LOCKED and RELOCK both follow the raster; RELOCK only differs in that
    // the frame has not yet been confirmed by a correctly placed sof.
    function automatic logic isCounting(input seqState_t s);
        return (s == ST_LOCKED) || (s == ST_RELOCK);
    endfunction

endpackage

// File: rtl/alt_vipcti131_common_raster_axis.sv
// ----------------------------------------------------------------------------
// alt_vipcti131_common_raster_axis
//
// Purpose : One wrapping raster axis counter (used once for H, once for V).
//           The count restarts at 0 on clear_i, otherwise steps on advance_i
//           and wraps back to 0 when an advance occurs at or above total_i.
//
// Ports   : clk          - rising-edge clock
//           reset_n      - asynchronous active-low reset
//           clear_i      - restart the count at 0 (wins over advance_i)
//           advance_i    - step the count this cycle
//           total_i      - last count value (total - 1)
//           count_o      - registered count
//           countNext_o  - value the count takes at the next edge
//           atLast_o     - count equals total_i
//           wrap_o       - next advance wraps (count >= total_i)
// ----------------------------------------------------------------------------
module alt_vipcti131_common_raster_axis
    import alt_vipcti131_common_pkg::*;
#(
    parameter int WIDTH = DEF_H_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic [WIDTH-1:0] total_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] countNext_o,
    output logic             atLast_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Wrap uses >= so that a total lowered mid-frame below the current
    // count still brings the count back to 0 at its next advance.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (advance_i) begin
            if (count_q >= total_i) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign countNext_o = count_d;
    assign atLast_o    = (count_q == total_i);
    assign wrap_o      = (count_q >= total_i);

endmodule

// File: rtl/alt_vipcti131_common_raster_sequencer.sv
// ----------------------------------------------------------------------------
// alt_vipcti131_common_raster_sequencer
//
// Purpose : Tracks the raster position of an incoming video stream. After an
//           enable it waits for a start-of-frame, then counts samples and
//           lines, flagging the active region, start of line and end of
//           frame. A sof arriving anywhere but the frame end is reported as
//           a mismatch and the sequencer relocks onto the new frame timing.
//
// Ports   : clk, reset_n            - clock, asynchronous active-low reset
//           enable                  - run; low returns to IDLE
//           valid_in, sof_in        - sample strobe, start-of-frame
//           h_total, v_total        - last count value per axis
//           h_active, v_active      - counts below these are active
//           ticks_per_sample        - valid_in strobes per count, minus 1
//           h_count, v_count        - current raster position
//           active, sol, eof        - active region, line start, frame end
//           locked, mismatch        - frame lock, one-cycle sof error pulse
//
// Config  : ALT_VIPCTI_RASTER_SEQ_TICKS_EN - when defined, a prescaler
//           divides valid_in by ticks_per_sample+1. When undefined every
//           valid_in is an advance and ticks_per_sample is ignored.
// ----------------------------------------------------------------------------
module alt_vipcti131_common_raster_sequencer
    import alt_vipcti131_common_pkg::*;
#(
    parameter int H_WIDTH     = DEF_H_WIDTH,
    parameter int V_WIDTH     = DEF_V_WIDTH,
    parameter int TICKS_WIDTH = DEF_TICKS_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   valid_in,
    input  logic                   sof_in,
    input  logic [H_WIDTH-1:0]     h_total,
    input  logic [V_WIDTH-1:0]     v_total,
    input  logic [H_WIDTH-1:0]     h_active,
    input  logic [V_WIDTH-1:0]     v_active,
    input  logic [TICKS_WIDTH-1:0] ticks_per_sample,
    output logic [H_WIDTH-1:0]     h_count,
    output logic [V_WIDTH-1:0]     v_count,
    output logic                   active,
    output logic                   sol,
    output logic                   eof,
    output logic                   locked,
    output logic                   mismatch
);

    seqState_t        state_q;
    seqState_t        state_d;
    logic             eof_q;
    logic             eof_d;
    logic             mismatch_q;
    logic             mismatch_d;
    logic             active_q;
    logic             active_d;
    logic             sol_q;
    logic             sol_d;

    logic             counting;
    logic             sofEvt;
    logic             advance;
    logic             vAdvance;
    logic             clearCounts;
    logic             frameEnd;
    logic             hLast;
    logic             hWrap;
    logic             vLast;
    logic             unusedVWrap;
    logic [H_WIDTH-1:0] hNext;
    logic [V_WIDTH-1:0] vNext;

    assign counting = isCounting(state_q);
    assign sofEvt   = valid_in && sof_in;
    assign frameEnd = hLast && vLast;

    // Counters sit at 0 outside the counting states, and every sof
    // (expected or not) restarts them at the origin of the new frame.
    assign clearCounts = !enable || !counting || sofEvt;
    assign vAdvance    = advance && hWrap;

`ifdef ALT_VIPCTI_RASTER_SEQ_TICKS_EN
    logic [TICKS_WIDTH-1:0] presc_q;
    logic [TICKS_WIDTH-1:0] presc_d;

    // Prescaler: an advance happens on the valid_in that finds the
    // prescaler at its terminal value. >= keeps it from running past a
    // terminal value that was lowered mid-count.
    always_comb begin
        presc_d = presc_q;
        advance = 1'b0;
        if (counting && valid_in) begin
            if (presc_q >= ticks_per_sample) begin
                advance = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        if (clearCounts) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    logic unusedTicks;

    assign advance     = counting && valid_in;
    assign unusedTicks = ^ticks_per_sample;
`endif

    alt_vipcti131_common_raster_axis #(
        .WIDTH (H_WIDTH)
    ) hAxis (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (clearCounts),
        .advance_i   (advance),
        .total_i     (h_total),
        .count_o     (h_count),
        .countNext_o (hNext),
        .atLast_o    (hLast),
        .wrap_o      (hWrap)
    );

    alt_vipcti131_common_raster_axis #(
        .WIDTH (V_WIDTH)
    ) vAxis (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (clearCounts),
        .advance_i   (vAdvance),
        .total_i     (v_total),
        .count_o     (v_count),
        .countNext_o (vNext),
        .atLast_o    (vLast),
        .wrap_o      (unusedVWrap)
    );

    // Frame lock FSM. A sof at the frame end confirms the timing; a sof
    // anywhere else flags a mismatch and drops to RELOCK until the frame
    // end is confirmed again. Dropping enable overrides everything.
    always_comb begin
        state_d    = state_q;
        mismatch_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (sofEvt) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED, ST_RELOCK: begin
                if (sofEvt) begin
                    if (frameEnd) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d    = ST_RELOCK;
                        mismatch_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!enable) begin
            state_d    = ST_IDLE;
            mismatch_d = 1'b0;
        end
    end

    // active and sol are computed from next-state values and registered,
    // so they line up with the registered counts without any path from
    // the inputs to the outputs.
    always_comb begin
        eof_d    = enable && advance && frameEnd;
        active_d = isCounting(state_d) && (hNext < h_active) && (vNext < v_active);
        sol_d    = isCounting(state_d) && (hNext == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            eof_q      <= 1'b0;
            mismatch_q <= 1'b0;
            active_q   <= 1'b0;
            sol_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            eof_q      <= eof_d;
            mismatch_q <= mismatch_d;
            active_q   <= active_d;
            sol_q      <= sol_d;
        end
    end

    assign locked   = (state_q == ST_LOCKED);
    assign active   = active_q;
    assign sol      = sol_q;
    assign eof      = eof_q;
    assign mismatch = mismatch_q;

endmodule

// File: tb/tb_alt_vipcti131_common_raster_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alt_vipcti131_common_raster_sequencer
//
// Scoreboard bench for the raster sequencer. Each test task pushes the
// expected output snapshot for a step, drives the step, then pops and
// compares against the DUT one time unit after the rising edge.
// Honours ALT_VIPCTI_RASTER_SEQ_TICKS_EN for the prescaler scenario.
// ----------------------------------------------------------------------------
module tb_alt_vipcti131_common_raster_sequencer;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        valid_in;
    logic        sof_in;
    logic [11:0] h_total;
    logic [11:0] v_total;
    logic [11:0] h_active;
    logic [11:0] v_active;
    logic [1:0]  ticks_per_sample;
    logic [11:0] h_count;
    logic [11:0] v_count;
    logic        active;
    logic        sol;
    logic        eof;
    logic        locked;
    logic        mismatch;

    typedef logic [28:0] snap_t;

    snap_t expQ[$];
    string tagQ[$];
    int    checkCount;
    int    failCount;

    alt_vipcti131_common_raster_sequencer #(
        .H_WIDTH     (12),
        .V_WIDTH     (12),
        .TICKS_WIDTH (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .valid_in         (valid_in),
        .sof_in           (sof_in),
        .h_total          (h_total),
        .v_total          (v_total),
        .h_active         (h_active),
        .v_active         (v_active),
        .ticks_per_sample (ticks_per_sample),
        .h_count          (h_count),
        .v_count          (v_count),
        .active           (active),
        .sol              (sol),
        .eof              (eof),
        .locked           (locked),
        .mismatch         (mismatch)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic snap_t mk(input int h, input int v, input logic a, input logic s,
                                 input logic e, input logic l, input logic m);
        logic [11:0] hv;
        logic [11:0] vv;
        hv = h[11:0];
        vv = v[11:0];
        return {hv, vv, a, s, e, l, m};
    endfunction

    function automatic snap_t snap();
        return {h_count, v_count, active, sol, eof, locked, mismatch};
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("h=%0d v=%0d act=%0b sol=%0b eof=%0b lck=%0b mm=%0b",
                         s[28:17], s[16:5], s[4], s[3], s[2], s[1], s[0]);
    endfunction

    // Drive one clock of stimulus and return just after the edge.
    task automatic tick(input logic v, input logic s);
        valid_in = v;
        sof_in   = s;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sof_in   = 1'b0;
    endtask

    // Reset values, then IDLE -> WAIT_SOF -> LOCKED, showing that sof is
    // ignored in IDLE and needs valid_in in WAIT_SOF.
    task automatic test_reset();
        snap_t obs;
        snap_t expVal;
        string tag;
        logic  vs[4];
        logic  ss[4];
        vs = '{1'b1, 1'b0, 1'b0, 1'b1};
        ss = '{1'b1, 1'b0, 1'b1, 1'b1};
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expQ.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tagQ.push_back("reset_values");
        obs = snap(); expVal = expQ.pop_front(); tag = tagQ.pop_front();
        checkCount++;
        if (obs !== expVal) begin
            failCount++;
            $display("[TB] FAIL %s: got %s, expected %s", tag, fmt(obs), fmt(expVal));
        end
        reset_n = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) expQ.push_back(mk(0, 0, 1, 1, 0, 1, 0));
            else        expQ.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            tagQ.push_back($sformatf("startup[%0d]", i));
            tick(vs[i], ss[i]);
            obs = snap(); expVal = expQ.pop_front(); tag = tagQ.pop_front();
            checkCount++;
            if (obs !== expVal) begin
                failCount++;
                $display("[TB] FAIL %s: got %s, expected %s", tag, fmt(obs), fmt(expVal));
            end
        end
    endtask

    // Totals 3/1, actives 2/1: eight advances cover a whole frame, with a
    // hold cycle (no valid_in) part way through.
    task automatic test_count();
        snap_t obs;
        snap_t expVal;
        string tag;
        int    h;
        int    v;
        for (int k = 1; k <= 8; k++) begin
            h = k % 4;
            v = (k / 4) % 2;
            expQ.push_back(mk(h, v, (h < 2) && (v < 1), h == 0, k == 8, 1, 0));
            tagQ.push_back($sformatf("count[%0d]", k));
            tick(1'b1, 1'b0);
            obs = snap(); expVal = expQ.pop_front(); tag = tagQ.pop_front();
            checkCount++;
            if (obs !== expVal) begin
                failCount++;
                $display("[TB] FAIL %s: got %s, expected %s", tag, fmt(obs), fmt(expVal));
            end
            if (k == 2 || k == 8) begin
                expQ.push_back(mk(h, v, (h < 2) && (v < 1), h == 0, 0, 1, 0));
                tagQ.push_back($sformatf("hold[%0d]", k));
                tick(1'b0, 1'b0);
                obs = snap(); expVal = expQ.pop_front(); tag = tagQ.pop_front();
                checkCount++;
                if (obs !== expVal) begin
                    failCount++;
                    $display("[TB] FAIL %s: got %s, expected %s", tag, fmt(obs), fmt(expVal));
                end
            end
        end
    endtask

    // Early sof at (1,0): mismatch pulse, RELOCK with counts restarted,
    // then a sof at the frame end restores lock.
    task automatic test_mismatch();
        snap_t obs;
        snap_t expVal;
        string tag;
        int    h;
        int    v;
        expQ.push_back(mk(1, 0, 1, 0, 0, 1, 0)); tagQ.push_back("pre_mismatch");
        tick(1'b1, 1'b0);
        obs = snap(); expVal = expQ.pop_front(); tag = tagQ.pop_front();
        checkCount++;
        if (obs !== expVal) begin
            failCount++;
            $display("[TB] FAIL %s: got %s, expected %s", tag, fmt(obs), fmt(expVal));
        end
        expQ.push_back(mk(0, 0, 1, 1, 0, 0, 1)); tagQ.push_back("mismatch_pulse");
        expQ.push_back(mk(0, 0, 1, 1, 0, 0, 0)); tagQ.push_back("mismatch_cleared");
        tick(1'b1, 1'b1);
        obs = snap(); expVal = expQ.pop_front(); tag = tagQ.pop_front();
        checkCount++;
        if (obs !== expVal) begin
            failCount++;
            $display("[TB] FAIL %s: got %s, expected %s", tag, fmt(obs), fmt(expVal));
        end
        tick(1'b0, 1'b0);
        obs = snap(); expVal = expQ.pop_front(); tag = tagQ.pop_front();
        checkCount++;
        if (obs !== expVal) begin
            failCount++;
            $display("[TB] FAIL %s: got %s, expected %s", tag, fmt(obs), fmt(expVal));
        end
        for (int k = 1; k <= 8; k++) begin
            h = k % 4;
            v = (k / 4) % 2;
            if (k == 8) expQ.push_back(mk(0, 0, 1, 1, 1, 1, 0));
            else        expQ.push_back(mk(h, v, (h < 2) && (v < 1), h == 0, 0, 0, 0));
            tagQ.push_back($sformatf("relock[%0d]", k));
            tick(1'b1, k == 8);
            obs = snap(); expVal = expQ.pop_front(); tag = tagQ.pop_front();
            checkCount++;
            if (obs !== expVal) begin
                failCount++;
                $display("[TB] FAIL %s: got %s, expected %s", tag, fmt(obs), fmt(expVal));
            end
        end
    endtask

    // ticks_per_sample=1 with continuous valid_in: every second valid_in
    // advances when the prescaler is built, every valid_in otherwise.
    task automatic test_ticks();
        snap_t obs;
        snap_t expVal;
        string tag;
        int    h;
        int    v;
        ticks_per_sample = 2'd1;
        for (int k = 1; k <= 6; k++) begin
`ifdef ALT_VIPCTI_RASTER_SEQ_TICKS_EN
            h = k / 2;
            v = 0;
`else
            h = k % 4;
            v = k / 4;
`endif
            expQ.push_back(mk(h, v, (h < 2) && (v < 1), h == 0, 0, 1, 0));
            tagQ.push_back($sformatf("ticks[%0d]", k));
            tick(1'b1, 1'b0);
            obs = snap(); expVal = expQ.pop_front(); tag = tagQ.pop_front();
            checkCount++;
            if (obs !== expVal) begin
                failCount++;
                $display("[TB] FAIL %s: got %s, expected %s", tag, fmt(obs), fmt(expVal));
            end
        end
        ticks_per_sample = 2'd0;
    endtask

    // Dropping enable while locked: IDLE and cleared counts next cycle,
    // then re-acquire lock.
    task automatic test_enable_drop();
        snap_t obs;
        snap_t expVal;
        string tag;
        logic  en[3];
        logic  vs[3];
        en = '{1'b0, 1'b1, 1'b1};
        vs = '{1'b0, 1'b0, 1'b1};
        expQ.push_back(mk(0, 0, 0, 0, 0, 0, 0)); tagQ.push_back("enable_low");
        expQ.push_back(mk(0, 0, 0, 0, 0, 0, 0)); tagQ.push_back("enable_wait_sof");
        expQ.push_back(mk(0, 0, 1, 1, 0, 1, 0)); tagQ.push_back("enable_relocked");
        for (int i = 0; i < 3; i++) begin
            enable = en[i];
            tick(vs[i], vs[i]);
            obs = snap(); expVal = expQ.pop_front(); tag = tagQ.pop_front();
            checkCount++;
            if (obs !== expVal) begin
                failCount++;
                $display("[TB] FAIL %s: got %s, expected %s", tag, fmt(obs), fmt(expVal));
            end
        end
    endtask

    // Zero totals: counts held at 0, every advance is a frame end, and a
    // sof there keeps lock without a mismatch.
    task automatic test_zero_totals();
        snap_t obs;
        snap_t expVal;
        string tag;
        h_total  = 12'd0;
        v_total  = 12'd0;
        h_active = 12'd1;
        v_active = 12'd1;
        for (int k = 1; k <= 5; k++) begin
            expQ.push_back(mk(0, 0, 1, 1, k != 5, 1, 0));
            tagQ.push_back($sformatf("zero_totals[%0d]", k));
            tick(k != 5, k == 4);
            obs = snap(); expVal = expQ.pop_front(); tag = tagQ.pop_front();
            checkCount++;
            if (obs !== expVal) begin
                failCount++;
                $display("[TB] FAIL %s: got %s, expected %s", tag, fmt(obs), fmt(expVal));
            end
        end
        h_active = 12'd2;
        v_active = 12'd1;
    endtask

    // Lowering h_total below the current count wraps at the next advance.
    task automatic test_total_change();
        snap_t obs;
        snap_t expVal;
        string tag;
        h_total = 12'd7;
        v_total = 12'd3;
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) begin
                h_total = 12'd3;
                expQ.push_back(mk(0, 1, 0, 1, 0, 1, 0));
            end else begin
                expQ.push_back(mk(k, 0, k < 2, 0, 0, 1, 0));
            end
            tagQ.push_back($sformatf("total_change[%0d]", k));
            tick(1'b1, 1'b0);
            obs = snap(); expVal = expQ.pop_front(); tag = tagQ.pop_front();
            checkCount++;
            if (obs !== expVal) begin
                failCount++;
                $display("[TB] FAIL %s: got %s, expected %s", tag, fmt(obs), fmt(expVal));
            end
        end
        v_total = 12'd1;
    endtask

    // Asynchronous reset mid-line at h=2 clears everything without a
    // clock edge; afterwards the sequencer starts again from IDLE.
    task automatic test_midframe_reset();
        snap_t obs;
        snap_t expVal;
        string tag;
        tick(1'b1, 1'b0);
        expQ.push_back(mk(2, 1, 0, 0, 0, 1, 0)); tagQ.push_back("before_reset");
        tick(1'b1, 1'b0);
        obs = snap(); expVal = expQ.pop_front(); tag = tagQ.pop_front();
        checkCount++;
        if (obs !== expVal) begin
            failCount++;
            $display("[TB] FAIL %s: got %s, expected %s", tag, fmt(obs), fmt(expVal));
        end
        expQ.push_back(mk(0, 0, 0, 0, 0, 0, 0)); tagQ.push_back("async_reset");
        #2;
        reset_n = 1'b0;
        #1;
        obs = snap(); expVal = expQ.pop_front(); tag = tagQ.pop_front();
        checkCount++;
        if (obs !== expVal) begin
            failCount++;
            $display("[TB] FAIL %s: got %s, expected %s", tag, fmt(obs), fmt(expVal));
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        expQ.push_back(mk(0, 0, 0, 0, 0, 0, 0)); tagQ.push_back("post_reset_wait_sof");
        expQ.push_back(mk(0, 0, 1, 1, 0, 1, 0)); tagQ.push_back("post_reset_locked");
        tick(1'b0, 1'b0);
        obs = snap(); expVal = expQ.pop_front(); tag = tagQ.pop_front();
        checkCount++;
        if (obs !== expVal) begin
            failCount++;
            $display("[TB] FAIL %s: got %s, expected %s", tag, fmt(obs), fmt(expVal));
        end
        tick(1'b1, 1'b1);
        obs = snap(); expVal = expQ.pop_front(); tag = tagQ.pop_front();
        checkCount++;
        if (obs !== expVal) begin
            failCount++;
            $display("[TB] FAIL %s: got %s, expected %s", tag, fmt(obs), fmt(expVal));
        end
    endtask

    initial begin
        checkCount       = 0;
        failCount        = 0;
        reset_n          = 1'b0;
        enable           = 1'b0;
        valid_in         = 1'b0;
        sof_in           = 1'b0;
        h_total          = 12'd3;
        v_total          = 12'd1;
        h_active         = 12'd2;
        v_active         = 12'd1;
        ticks_per_sample = 2'd0;
        $display("[TB] starting raster sequencer bench");
        test_reset();
        test_count();
        test_mismatch();
        test_ticks();
        test_enable_drop();
        test_zero_totals();
        test_total_change();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/alt_vipcti131_common_raster_sequencer.md
ALT_VIPCTI131_COMMON_RASTER_SEQUENCER -- requirements
Module: alt_vipcti131_common_raster_sequencer

Interface
REQ-001 SHALL have parameter H_WIDTH, default 12: horizontal count width.
REQ-002 SHALL have parameter V_WIDTH, default 12: vertical count width.
REQ-003 SHALL have parameter TICKS_WIDTH, default 2: tick prescaler width.
REQ-004 SHALL have port clk  in  1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port enable  in  1: sequencer run; low forces IDLE.
REQ-007 SHALL have port valid_in  in  1: input sample strobe; counting advances only on it.
REQ-008 SHALL have port sof_in  in  1: start-of-frame pulse, qualified by valid_in.
REQ-009 SHALL have port h_total, v_total  in  H_WIDTH/V_WIDTH: last count value, i.e. total-1.
REQ-010 SHALL have port h_active, v_active  in  H_WIDTH/V_WIDTH: active samples/lines, i.e. count values below this are active.
REQ-011 SHALL have port ticks_per_sample  in  TICKS_WIDTH: ticks per count, minus 1.
REQ-012 SHALL have port h_count, v_count  out  H_WIDTH/V_WIDTH: current raster position.
REQ-013 SHALL have port active, sol, eof  out  1 each: active region; first sample of line; last sample of frame.
REQ-014 SHALL have port locked, mismatch  out  1 each: frame lock; one-cycle error pulse.

Function
REQ-015 SHALL implement the states IDLE, WAIT_SOF, LOCKED and RELOCK.
REQ-016 IDLE->WAIT_SOF SHALL occur when enable=1; any state ->IDLE SHALL occur when enable=0, with counters cleared next cycle.
REQ-017 WAIT_SOF->LOCKED SHALL occur on valid_in&sof_in; h_count and v_count SHALL load 0 on that cycle.
REQ-018 In LOCKED, each advance SHALL increment h_count; at h_count==h_total, h_count SHALL wrap to 0 and v_count SHALL increment, wrapping to 0 at v_total.
REQ-019 An advance SHALL be valid_in when ticks_per_sample==0; otherwise it SHALL be the valid_in cycle on which the prescaler equals ticks_per_sample.
REQ-020 sof_in in LOCKED at h_count==h_total and v_count==v_total SHALL be the expected case: counters wrap to 0 and the state stays LOCKED.
REQ-021 sof_in in LOCKED at any other position SHALL pulse mismatch for 1 cycle, restart counters to 0 and enter RELOCK.
REQ-022 RELOCK SHALL count as LOCKED does; the next sof_in at the frame end SHALL return the state to LOCKED, and any other sof_in SHALL repeat REQ-021.
REQ-023 locked SHALL be 1 only in LOCKED.
REQ-024 active SHALL be (h_count<h_active)&&(v_count<v_active) in LOCKED/RELOCK, and 0 otherwise.
REQ-025 sol SHALL be 1 when h_count==0 and a count is pending; eof SHALL be 1 on the advance at h_total,v_total.
REQ-026 Outputs SHALL be registered or decoded from registers only, with no combinational path from inputs.
REQ-027 Comparisons SHALL be unsigned; h_total/v_total of 0 SHALL give a count held at 0, with every advance wrapping.
REQ-028 Totals changed mid-frame SHALL take effect immediately; a count above the new total SHALL wrap at its next advance.

Reset
REQ-029 Reset SHALL force IDLE; counts, prescaler, active, sol, eof, locked and mismatch SHALL all be 0.
REQ-030 Reset SHALL act mid-frame without waiting for a line or frame boundary.

Configuration
REQ-031 Macro ALT_VIPCTI_RASTER_SEQ_TICKS_EN SHALL control the tick prescaler.
- Defined: the prescaler operates per REQ-019; sof_in clears it.
- Undefined: the prescaler and ticks_per_sample logic are absent, every valid_in is an advance, and the port stays present but is ignored.

Structure
REQ-032 The shared package alt_vipcti131_common_pkg SHALL hold the state enum and the width defaults.
REQ-033 A sub-module alt_vipcti131_common_raster_axis SHALL provide one wrapping axis counter with restart, instantiated for H and V.

Verification
REQ-034 h_total=3, v_total=1, ticks=0, sof, then 8 valid_in -> h_count 0,1,2,3,0,1,2,3; v_count 0,0,0,0,1,1,1,1; eof on the 8th.
REQ-035 sof_in at h=1,v=0 while LOCKED -> mismatch one cycle, counts 0, locked=0; next sof at frame end -> locked=1.
REQ-036 Macro defined, ticks_per_sample=1, continuous valid_in -> h_count advances every 2nd cycle.
REQ-037 h_active=2, v_active=1 with totals 3/1 -> active only at (0,0) and (1,0).
REQ-038 reset_n low mid-line at h=2 -> all outputs 0 immediately, IDLE; after release and enable=1 -> WAIT_SOF.
REQ-039 enable dropped in LOCKED -> next cycle IDLE, locked=0, counts 0.
